reaction_counter: RTL and testbench

Millisecond-resolution elapsed-time counter feeding the reaction-timer master controller. Divides the system clock down to a tick, and keeps a 5-digit packed-BCD count for display and switch selection alongside an equal-valued binary count for comparison against the saved random delay. The controller drives `clreset` to clear and hold the counter and reads `count` and `count_binary` every cycle.

---
 rtl/reaction_counter.sv | 124 ++++++++++++
 tb/tb_reaction_counter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_counter.sv
// ============================================================================
//  Module      : reaction_counter
//  Description : Millisecond elapsed-time counter for the reaction-timer
//                controller. A prescaler divides clk down to a tick; each
//                tick advances a 5-digit packed-BCD count and an equal-valued
//                binary count. clreset clears and holds, hold freezes.
//  Config      : REACTION_COUNTER_SATURATE_EN
//                  defined   -> count saturates at 99999 on overflow
//                  undefined -> count wraps to 00000 on overflow
//                Either way ovf is set sticky on the overflowing advance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reaction_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clreset,
    input  logic        hold,
    output logic [19:0] count,
    output logic [19:0] count_binary,
    output logic        tick,
    output logic        ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] C_PRE_LAST = PW'(DIV - 1);
    localparam logic [19:0]   C_BCD_MAX  = 20'h99999;
    localparam logic [19:0]   C_BIN_MAX  = 20'd99999;

    // A divider below 2 cannot produce a one-cycle tick between idle cycles.
    generate
        if (DIV < 2) begin : g_div_check
            $error("reaction_counter: CLK_HZ / TICK_HZ must be at least 2");
        end
    endgenerate

    logic [PW-1:0] r_pre;
    logic [19:0]   r_count;
    logic [19:0]   r_count_bin;
    logic          r_tick;
    logic          r_ovf;

    logic [19:0]   w_bcd_inc;
    logic          w_carry;
    logic          w_at_max;
    logic [19:0]   w_next_count;
    logic [19:0]   w_next_bin;

    // BCD increment with the carry rippling through all five digits.
    always_comb begin
        w_bcd_inc = r_count;
        w_carry   = 1'b1;
        for (int d = 0; d < 5; d++) begin
            if (w_carry) begin
                if (r_count[4*d +: 4] >= 4'd9) begin
                    w_bcd_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    // Next count values, including the terminal-value policy.
    always_comb begin
        w_at_max     = (r_count == C_BCD_MAX);
        w_next_count = w_bcd_inc;
        w_next_bin   = r_count_bin + 20'd1;
        if (w_at_max) begin
`ifdef REACTION_COUNTER_SATURATE_EN
            w_next_count = C_BCD_MAX;
            w_next_bin   = C_BIN_MAX;
`else
            w_next_count = 20'h00000;
            w_next_bin   = 20'd0;
`endif
        end
    end

    // Prescaler and count registers: clear, then hold, then count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_count     <= '0;
            r_count_bin <= '0;
            r_tick      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clreset) begin
            r_pre       <= '0;
            r_count     <= '0;
            r_count_bin <= '0;
            r_tick      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (hold) begin
            r_tick      <= 1'b0;
        end else if (r_pre == C_PRE_LAST) begin
            r_pre       <= '0;
            r_count     <= w_next_count;
            r_count_bin <= w_next_bin;
            r_tick      <= 1'b1;
            if (w_at_max) begin
                r_ovf   <= 1'b1;
            end
        end else begin
            r_pre       <= r_pre + PW'(1);
            r_tick      <= 1'b0;
        end
    end

    assign count        = r_count;
    assign count_binary = r_count_bin;
    assign tick         = r_tick;
    assign ovf          = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_reaction_counter.sv
// ============================================================================
//  Module      : tb_reaction_counter
//  Description : Scoreboard bench for reaction_counter (DIV = 10). Stimulus
//                pushes the expected value of each advance; a monitor pops
//                and compares on every tick and checks BCD/binary agreement
//                every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reaction_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clreset;
    logic        hold;
    logic [19:0] count;
    logic [19:0] count_binary;
    logic        tick;
    logic        ovf;

    reaction_counter #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clreset      (clreset),
        .hold         (hold),
        .count        (count),
        .count_binary (count_binary),
        .tick         (tick),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic [19:0] bin;
        logic        ovf;
        int          gap;   // edges since previous tick/clear; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges   = 0;
    logic prev_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          t;
        r = '0;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] bcd_val(input logic [19:0] b);
        logic [31:0] acc;
        acc = '0;
        for (int d = 4; d >= 0; d--) begin
            if (b[4*d +: 4] > 4'd9) return 32'hFFFF_FFFF;
            acc = acc * 32'd10 + 32'(b[4*d +: 4]);
        end
        return acc;
    endfunction

    // Enabled-edge counter used to measure tick spacing.
    always @(posedge clk) begin
        if (!rst_n || clreset) edges = 0;
        else                   edges = edges + 1;
    end

    // Monitor: per-cycle invariant, tick width, and scoreboard on each tick.
    always @(negedge clk) begin
        if (rst_n) begin
            check("bin_eq_bcd", 32'(count_binary), bcd_val(count));
            if (prev_tick) check("tick_width", 32'(tick), 32'h0);
            if (tick) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tick: got count %0h, expected no tick at %0t", count, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("adv_count", 32'(count), 32'(e.bcd));
                    check("adv_binary", 32'(count_binary), 32'(e.bin));
                    check("adv_ovf", 32'(ovf), 32'(e.ovf));
                    if (e.gap != 0) check("tick_gap", 32'(edges), 32'(e.gap));
                end
                edges = 0;
            end
        end
        prev_tick = tick;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int v, input logic ov, input int gap);
        exp_t x;
        x.bcd = to_bcd(v);
        x.bin = 20'(v);
        x.ovf = ov;
        x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < budget);
        if (!tick) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", budget);
        end
        #1;
    endtask

    task automatic preload(input logic [19:0] b, input logic [19:0] v);
        hold = 1'b1;
        step();
        force dut.r_count     = b;
        force dut.r_count_bin = v;
        step();
        release dut.r_count;
        release dut.r_count_bin;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        clreset = 1'b0;
        hold    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_count", 32'(count), 32'h0);
        check("reset_binary", 32'(count_binary), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;

        // Run to 00042, then assert reset between clock edges.
        for (int i = 1; i <= 42; i++) begin
            push(i, 1'b0, 10);
            wait_tick(40);
        end
        check("pre_reset_count", 32'(count), 32'h00042);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_count", 32'(count), 32'h0);
        check("async_reset_binary", 32'(count_binary), 32'h0);
        check("async_reset_ovf", 32'(ovf), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            push(i, 1'b0, 10);
            wait_tick(40);
        end

        // Clear-and-start.
        clreset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("clear_count", 32'(count), 32'h0);
            check("clear_tick", 32'(tick), 32'h0);
        end
        #1 clreset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            push(i, 1'b0, 10);
            wait_tick(40);
        end

        // BCD carries 00099 -> 00100 and 09999 -> 10000.
        preload(20'h00098, 20'd98);
        hold = 1'b0;
        push(99, 1'b0, 0);
        wait_tick(40);
        push(100, 1'b0, 10);
        wait_tick(40);
        preload(20'h09998, 20'd9998);
        hold = 1'b0;
        push(9999, 1'b0, 0);
        wait_tick(40);
        push(10000, 1'b0, 10);
        wait_tick(40);

        // Hold for 7 cycles mid-interval stretches it to 17 edges.
        repeat (3) @(negedge clk);
        #1 hold = 1'b1;
        repeat (7) begin
            @(negedge clk);
            check("hold_tick", 32'(tick), 32'h0);
            check("hold_count", 32'(count), 32'h10000);
        end
        #1 hold = 1'b0;
        push(10001, 1'b0, 17);
        wait_tick(40);

        // Clear in the cycle where the prescaler sits at DIV-1.
        repeat (9) @(negedge clk);
        #1 clreset = 1'b1;
        @(negedge clk);
        check("collide_count", 32'(count), 32'h0);
        check("collide_binary", 32'(count_binary), 32'h0);
        check("collide_tick", 32'(tick), 32'h0);
        check("collide_ovf", 32'(ovf), 32'h0);
        #1 clreset = 1'b0;
        push(1, 1'b0, 10);
        wait_tick(40);

        // Terminal value behaviour.
        preload(20'h99998, 20'd99998);
        hold = 1'b0;
        push(99999, 1'b0, 0);
        wait_tick(40);
`ifdef REACTION_COUNTER_SATURATE_EN
        push(99999, 1'b1, 10);
        wait_tick(40);
        push(99999, 1'b1, 10);
        wait_tick(40);
`else
        push(0, 1'b1, 10);
        wait_tick(40);
        push(1, 1'b1, 10);
        wait_tick(40);
`endif
        clreset = 1'b1;
        @(negedge clk);
        check("clear_ovf", 32'(ovf), 32'h0);
        check("clear_after_ovf_count", 32'(count), 32'h0);
        #1 clreset = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
